// File: rtl/fp_expander_pkg.sv
// Shared definitions for the float datapath: field positions, widths, FSM states.
package fp_expander_pkg;

  localparam int unsigned FP_EXP_W = 3;
  localparam int unsigned FP_SIG_W = 4;
  localparam int unsigned FP_OUT_W = 12;
  localparam int unsigned FP_IN_W  = 1 + FP_EXP_W + FP_SIG_W;

  localparam int unsigned SIGN_BIT = 7;
  localparam int unsigned EXP_MSB  = 6;
  localparam int unsigned EXP_LSB  = 4;
  localparam int unsigned SIG_MSB  = 3;
  localparam int unsigned SIG_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/fp_expander_negate.sv
// Combinational conditional two's-complement: y = neg ? -x : x.
module fp_negate #(
  parameter int unsigned W = 12
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  // Negating zero wraps back to zero, so no special case is needed.
  always_comb begin
    y = x;
    if (neg) y = ~x + {{(W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/fp_expander.sv
// Decodes an S/E3/F4 float code into a 12-bit two's-complement value using
// a serial left shifter; valid/ready handshakes on both sides.
module fp_expander
  import fp_expander_pkg::*;
#(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned SIG_W = FP_SIG_W,
  parameter int unsigned OUT_W = FP_OUT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_IN_W-1:0]  in_float,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_linear
);

  state_t            state;
  state_t            state_nx;
  logic [OUT_W-1:0]  mag;
  logic [OUT_W-1:0]  mag_signed;
  logic [EXP_W-1:0]  count;
  logic              sign;
  logic              accept;

  assign accept = in_valid && in_ready;

  fp_negate #(.W(OUT_W)) u_negate (
    .neg (sign),
    .x   (mag),
    .y   (mag_signed)
  );

  // State register; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_SHIFT;
      ST_SHIFT: if (count == '0) state_nx = ST_OUT;
      ST_OUT:   if (out_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure functions of the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready  = 1'b1;
      ST_OUT:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on accept, shift once per cycle, latch the signed result.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag        <= '0;
      count      <= '0;
      sign       <= 1'b0;
      out_linear <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mag   <= {{(OUT_W-SIG_W){1'b0}}, in_float[SIG_MSB:SIG_LSB]};
            count <= in_float[EXP_MSB:EXP_LSB];
            sign  <= in_float[SIGN_BIT];
          end
        end
        ST_SHIFT: begin
          if (count != '0) begin
            mag   <= {mag[OUT_W-2:0], 1'b0};
            count <= count - 1'b1;
          end else begin
            out_linear <= mag_signed;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_expander.sv
// Directed bench for fp_expander with a scoreboard of expected results.
module tb_fp_expander;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_float;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_linear;

  typedef struct {
    logic [11:0] val;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fp_expander dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_float   (in_float),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_linear (out_linear)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a code, wait for acceptance, and record the expected result.
  task automatic send(input logic [7:0] code, input logic [11:0] val);
    int cyc = 0;
    while (!in_ready && cyc < 20) begin
      step();
      cyc++;
    end
    chk("in_ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    in_float = code;
    step();
    in_valid = 1'b0;
    chk("accepted", in_ready, 0);
    sb.push_back('{val, code[6:4] + 1});
  endtask

  // Wait for a result, check it against the scoreboard, optionally backpressure.
  task automatic collect(input int hold, input bit toggle, input bit keep_ready);
    int   cyc = 0;
    exp_t e;
    while (!out_valid && cyc < 20) begin
      if (toggle) begin
        in_valid = 1'($urandom_range(0, 1));
        in_float = 8'($urandom);
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("out_valid_seen", out_valid, 1);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("latency", cyc, e.lat);
    chk("out_linear", out_linear, e.val);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      if (toggle) begin
        in_valid = 1'($urandom_range(0, 1));
        in_float = 8'($urandom);
      end
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_stable", out_linear, e.val);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    if (!keep_ready) out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_float  = 8'h00;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_linear", out_linear, 12'h000);

    send(8'h00, 12'h000); collect(0, 1'b0, 1'b0);
    send(8'h3A, 12'h050); collect(5, 1'b1, 1'b0);
    send(8'hBA, 12'hFB0); collect(2, 1'b1, 1'b0);
    send(8'h7F, 12'h780); collect(0, 1'b0, 1'b0);
    send(8'hFF, 12'h880); collect(1, 1'b0, 1'b0);
    send(8'h80, 12'h000); collect(0, 1'b0, 1'b0);

    // Reset in the middle of a long shift: result must be discarded.
    send(8'h7F, 12'h780);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_linear", out_linear, 12'h000);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen = 1;
      step();
    end
    chk("midreset_no_pulse", seen, 0);

    send(8'h15, 12'h00A); collect(0, 1'b0, 1'b0);

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    send(8'h21, 12'h004); collect(0, 1'b0, 1'b1);
    send(8'h42, 12'h020); collect(0, 1'b0, 1'b1);
    send(8'hC3, 12'hFD0); collect(0, 1'b0, 1'b1);
    out_ready = 1'b0;

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
